// File: rtl/melody_player.sv
// melody_player: plays a fixed melody from an internal ROM.
//   Drives a voice code to an external note selector, turns the returned
//   half-period count into a square wave, and times each note in beats.
//   A silent gap is inserted between notes.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   1-cycle pulse, begins playback at ROM entry 0
//   stop      in   aborts playback (wins over start)
//   note_div  in   half-period count for the current voice (0 = silent)
//   voice     out  voice code to the note selector (0 outside NOTE)
//   audio     out  square wave to the buzzer
//   busy      out  high while in NOTE or GAP
//   done      out  1-cycle pulse at end of song
//   note_idx  out  current ROM index
//
// Build option: define LOOP_EN to repeat the song until stop.
//   The done pulse still appears once per pass, but busy stays high.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start, outputs silent
//   NOTE   | playing rom[note_idx] for beats*BEAT_DIV cycles
//   GAP    | silent pause of GAP_CYC cycles between notes
//   DONE   | one-cycle end-of-song marker
module melody_player #(
  parameter int unsigned BEAT_DIV = 10_000_000,
  parameter int unsigned GAP_CYC  = 400_000,
  parameter int unsigned SONG_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [19:0] note_div,
  output logic [3:0]  voice,
  output logic        audio,
  output logic        busy,
  output logic        done,
  output logic [4:0]  note_idx
);

`ifdef LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [31:0] SUB_LOAD = 32'(BEAT_DIV - 1);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYC - 1);
  localparam logic [5:0]  LEN      = 6'(SONG_LEN);

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] sub_q, sub_d;
  logic [31:0] gap_q, gap_d;
  logic [19:0] tone_q, tone_d;
  logic        audio_q, audio_d;
  logic        busy_q, busy_d;

  // Song ROM, entry = {voice, beats}; beats == 0 terminates the song.
  function automatic logic [3:0] rom_voice(input logic [4:0] a);
    case (a)
      5'd0:    rom_voice = 4'h6;
      5'd1:    rom_voice = 4'hA;
      5'd2:    rom_voice = 4'h6;
      default: rom_voice = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] rom_beats(input logic [4:0] a);
    case (a)
      5'd0:    rom_beats = 4'd2;
      5'd1:    rom_beats = 4'd1;
      5'd2:    rom_beats = 4'd1;
      default: rom_beats = 4'd0;
    endcase
  endfunction

  logic [5:0] nxt_idx;
  logic [3:0] beats0, nxt_beats;
  logic       song_end;

  assign nxt_idx   = {1'b0, idx_q} + 6'd1;
  assign beats0    = rom_beats(5'd0);
  assign nxt_beats = rom_beats(nxt_idx[4:0]);
  assign song_end  = (nxt_idx >= LEN) || (nxt_beats == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      sub_q   <= '0;
      gap_q   <= '0;
      tone_q  <= '0;
      audio_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      sub_q   <= sub_d;
      gap_q   <= gap_d;
      tone_q  <= tone_d;
      audio_q <= audio_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    sub_d   = sub_q;
    gap_d   = gap_q;
    tone_d  = tone_q;
    audio_d = audio_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (beats0 == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_NOTE;
            beat_d  = {28'd0, beats0};
            sub_d   = SUB_LOAD;
            tone_d  = '0;
            audio_d = 1'b0;
          end
        end
      end

      S_NOTE: begin
        // >= rather than == so a shrinking note_div cannot run the counter away.
        if (note_div == 20'd0) begin
          tone_d  = '0;
          audio_d = 1'b0;
        end else if (tone_q >= note_div - 20'd1) begin
          tone_d  = '0;
          audio_d = ~audio_q;
        end else begin
          tone_d  = tone_q + 20'd1;
        end

        if (sub_q == 32'd0) begin
          if (beat_q <= 32'd1) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
            beat_d  = '0;
            sub_d   = '0;
            tone_d  = '0;
            audio_d = 1'b0;
          end else begin
            beat_d  = beat_q - 32'd1;
            sub_d   = SUB_LOAD;
          end
        end else begin
          sub_d = sub_q - 32'd1;
        end
      end

      S_GAP: begin
        if (gap_q == 32'd0) begin
          if (song_end) begin
            state_d = S_DONE;
          end else begin
            state_d = S_NOTE;
            idx_d   = nxt_idx[4:0];
            beat_d  = {28'd0, nxt_beats};
            sub_d   = SUB_LOAD;
            tone_d  = '0;
            audio_d = 1'b0;
          end
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end

      S_DONE: begin
        idx_d = '0;
        if (LOOP && beats0 != 4'd0) begin
          state_d = S_NOTE;
          beat_d  = {28'd0, beats0};
          sub_d   = SUB_LOAD;
          tone_d  = '0;
          audio_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      beat_d  = '0;
      sub_d   = '0;
      gap_d   = '0;
      tone_d  = '0;
      audio_d = 1'b0;
    end

    // When looping, the DONE cycle is part of continuous playback.
    busy_d = (state_d == S_NOTE) || (state_d == S_GAP) ||
             (LOOP && state_d == S_DONE);
  end

  always_comb begin
    voice    = (state_q == S_NOTE) ? rom_voice(idx_q) : 4'h0;
    audio    = audio_q;
    busy     = busy_q;
    done     = (state_q == S_DONE);
    note_idx = idx_q;
  end

endmodule

// File: tb/tb_melody_player.sv
module tb_melody_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [19:0] note_div;
  logic [3:0]  voice;
  logic        audio, busy, done;
  logic [4:0]  note_idx;

  always #5 clk = ~clk;

  // Note selector stub.
  always_comb begin
    if (voice == 4'h6)      note_div = 20'd3;
    else if (voice == 4'hA) note_div = 20'd2;
    else                    note_div = 20'd0;
  end

  melody_player #(.BEAT_DIV(4), .GAP_CYC(2), .SONG_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .note_div(note_div), .voice(voice), .audio(audio), .busy(busy),
    .done(done), .note_idx(note_idx)
  );

  typedef struct packed {
    logic [3:0]  tid;
    logic [15:0] tag;
    logic [3:0]  voice;
    logic        audio;
    logic        busy;
    logic        done;
    logic [4:0]  idx;
    logic        chk_idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tid = 0;
  int   cyc_no = 0;

  // Expected outputs k cycles after the start-sample cycle (k = 0).
  function automatic exp_t song_exp(input int k);
    exp_t e;
    int j;
    e = '0;
    e.chk_idx = 1'b1;
    j = k;
`ifdef LOOP_EN
    if (k >= 1) j = ((k - 1) % 23) + 1;
`endif
    if (j >= 1 && j <= 8) begin
      e.voice = 4'h6; e.busy = 1'b1; e.idx = 5'd0; e.audio = 1'(((j - 1) / 3) % 2);
    end else if (j >= 9 && j <= 10) begin
      e.busy = 1'b1; e.idx = 5'd0;
    end else if (j >= 11 && j <= 14) begin
      e.voice = 4'hA; e.busy = 1'b1; e.idx = 5'd1; e.audio = 1'(((j - 11) / 2) % 2);
    end else if (j >= 15 && j <= 16) begin
      e.busy = 1'b1; e.idx = 5'd1;
    end else if (j >= 17 && j <= 20) begin
      e.voice = 4'h6; e.busy = 1'b1; e.idx = 5'd2; e.audio = 1'(((j - 17) / 3) % 2);
    end else if (j >= 21 && j <= 22) begin
      e.busy = 1'b1; e.idx = 5'd2;
    end else if (j == 23) begin
      e.done = 1'b1; e.chk_idx = 1'b0;
`ifdef LOOP_EN
      e.busy = 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic cyc(input logic s, input logic p, input logic r, input exp_t e);
    exp_t x;
    @(posedge clk);
    #1;
    start = s;
    stop  = p;
    rst_n = r;
    x = e;
    x.tid = 4'(tid);
    x.tag = 16'(cyc_no);
    cyc_no++;
    exp_q.push_back(x);
  endtask

  task automatic new_test(input int t);
    tid = t;
    cyc_no = 0;
  endtask

  // Monitor: one scoreboard entry per presented output cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      got_e = exp_q.pop_front();
      n_cmp++;
      if (voice !== got_e.voice || audio !== got_e.audio || busy !== got_e.busy ||
          done !== got_e.done || (got_e.chk_idx && note_idx !== got_e.idx)) begin
        n_bad++;
        $display("FAIL test%0d step%0d: got voice=%h audio=%b busy=%b done=%b idx=%0d, want voice=%h audio=%b busy=%b done=%b idx=%0d",
                 got_e.tid, got_e.tag, voice, audio, busy, done, note_idx,
                 got_e.voice, got_e.audio, got_e.busy, got_e.done, got_e.idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held, then idle after release.
    new_test(0);
    for (int i = 0; i < 3; i++)  cyc(1'b0, 1'b0, 1'b0, song_exp(0));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, song_exp(0));

    // Full song, stopped afterwards (ends the loop if enabled).
    new_test(1);
    cyc(1'b1, 1'b0, 1'b1, song_exp(0));
    for (int k = 1; k <= 27; k++) cyc(1'b0, 1'b0, 1'b1, song_exp(k));
    cyc(1'b0, 1'b1, 1'b1, song_exp(28));
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, song_exp(30));
    if (1) begin end

    // Same song with a start pulse at cycle 5 that must be ignored.
    new_test(2);
    cyc(1'b1, 1'b0, 1'b1, song_exp(0));
    for (int k = 1; k <= 27; k++) cyc((k == 5) ? 1'b1 : 1'b0, 1'b0, 1'b1, song_exp(k));
    cyc(1'b0, 1'b1, 1'b1, song_exp(28));
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, song_exp(0));

    // Stop at cycle 12, then replay from entry 0.
    new_test(3);
    cyc(1'b1, 1'b0, 1'b1, song_exp(0));
    for (int k = 1; k <= 11; k++) cyc(1'b0, 1'b0, 1'b1, song_exp(k));
    cyc(1'b0, 1'b1, 1'b1, song_exp(12));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, song_exp(0));
    cyc(1'b1, 1'b0, 1'b1, song_exp(0));
    for (int k = 1; k <= 10; k++) cyc(1'b0, 1'b0, 1'b1, song_exp(k));
    cyc(1'b0, 1'b1, 1'b1, song_exp(11));
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, song_exp(0));

    // start and stop together in IDLE: stays idle.
    new_test(4);
    cyc(1'b1, 1'b1, 1'b1, song_exp(0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, song_exp(0));

    // Asynchronous reset in the middle of a note.
    new_test(5);
    cyc(1'b1, 1'b0, 1'b1, song_exp(0));
    for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b0, 1'b1, song_exp(k));
    cyc(1'b0, 1'b0, 1'b0, song_exp(0));
    cyc(1'b0, 1'b0, 1'b0, song_exp(0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, song_exp(0));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
